// File: rtl/clk_div_tick.sv
// clk_div_tick: turns rising edges of a selected divider output into
// one-cycle ticks, counts them against a terminal count and watches the
// divider's 3-bit count sequence for corruption (sticky error flag).
module clk_div_tick (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] div_in,
    input  logic [1:0] sel,
    input  logic       enable,
    input  logic [7:0] tc,
    input  logic       err_clr,
    output logic       tick,
    output logic [7:0] cnt,
    output logic       wrap,
    output logic       err
);

    logic [2:0] r_div_q;
    logic       r_chk_vld;
    logic       r_tick;
    logic [7:0] r_cnt;
    logic       r_wrap;
    logic       r_err;

    logic       w_sel_cur;
    logic       w_sel_prev;
    logic       w_rise;
    logic [2:0] w_div_next;
    logic       w_viol;

    // Pick the current and previous sample of the selected divider bit;
    // sel = 3 selects nothing, so no rise can ever be seen.
    always_comb begin
        w_sel_cur  = 1'b0;
        w_sel_prev = 1'b0;
        case (sel)
            2'd0: begin
                w_sel_cur  = div_in[0];
                w_sel_prev = r_div_q[0];
            end
            2'd1: begin
                w_sel_cur  = div_in[1];
                w_sel_prev = r_div_q[1];
            end
            2'd2: begin
                w_sel_cur  = div_in[2];
                w_sel_prev = r_div_q[2];
            end
            default: begin
                w_sel_cur  = 1'b0;
                w_sel_prev = 1'b0;
            end
        endcase
    end

    assign w_rise     = enable & w_sel_cur & ~w_sel_prev;

    // The divider must advance by one (mod 8) each clock; a divider held
    // at zero (its own reset) is also legal.
    assign w_div_next = 3'(r_div_q + 3'd1);
    assign w_viol     = r_chk_vld
                        & (div_in != w_div_next)
                        & ~((div_in == 3'd0) & (r_div_q == 3'd0));

    // Sample the divider and arm the sequence checker one clock after reset
    // so the first sample is never compared with the reset value of div_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div_q   <= 3'd0;
            r_chk_vld <= 1'b0;
        end else begin
            r_div_q   <= div_in;
            r_chk_vld <= 1'b1;
        end
    end

    // Tick, counter and wrap all move on the same edge; cnt >= tc (rather
    // than ==) makes a lowered tc wrap on the next rise and caps cnt at 255.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick <= 1'b0;
            r_cnt  <= 8'd0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_rise;
            r_wrap <= 1'b0;
            if (w_rise) begin
                if (r_cnt >= tc) begin
                    r_cnt  <= 8'd0;
                    r_wrap <= 1'b1;
                end else begin
                    r_cnt  <= r_cnt + 8'd1;
                end
            end
        end
    end

    // Sticky error: a violation sets it and beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_viol) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign tick = r_tick;
    assign cnt  = r_cnt;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule

// File: tb/tb_clk_div_tick.sv
// Directed bench for clk_div_tick: each scenario task drives the divider
// sequence and compares tick/cnt/wrap/err against hand-computed values.
module tb_clk_div_tick;

    logic       clk;
    logic       reset;
    logic [2:0] div_in;
    logic [1:0] sel;
    logic       enable;
    logic [7:0] tc;
    logic       err_clr;
    logic       tick;
    logic [7:0] cnt;
    logic       wrap;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Vector tables reused by the directed scenarios
    logic [2:0] d_v [8];
    logic [7:0] c_v [8];
    logic       t_v [8];
    logic       w_v [8];
    logic       e_v [8];

    clk_div_tick dut (
        .clk     (clk),
        .reset   (reset),
        .div_in  (div_in),
        .sel     (sel),
        .enable  (enable),
        .tc      (tc),
        .err_clr (err_clr),
        .tick    (tick),
        .cnt     (cnt),
        .wrap    (wrap),
        .err     (err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one divider sample at the falling edge, then step
    // past the next rising edge so outputs can be sampled safely.
    task automatic cyc(input logic [2:0] d);
        @(negedge clk);
        div_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        div_in  = 3'd5;
        sel     = 2'd0;
        enable  = 1'b1;
        tc      = 8'd3;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0d expected 0", tick); end
        n_checks++; if (cnt !== 8'd0)  begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %0d expected 0", wrap); end
        n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err); end
        @(negedge clk);
        div_in = 3'd0;
        reset  = 1'b1;
    endtask

    // sel=0, tc=3: tick every other cycle, cnt 1,2,3,0 with wrap on the 0
    task automatic test_basic();
        sel = 2'd0; enable = 1'b1; tc = 8'd3;
        d_v = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        t_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        c_v = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd0};
        w_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cyc(d_v[i]);
            n_checks++; if (tick !== t_v[i]) begin n_fail++; $display("FAIL basic_tick[%0d]: got %0d expected %0d", i, tick, t_v[i]); end
            n_checks++; if (cnt !== c_v[i])  begin n_fail++; $display("FAIL basic_cnt[%0d]: got %0d expected %0d", i, cnt, c_v[i]); end
            n_checks++; if (wrap !== w_v[i]) begin n_fail++; $display("FAIL basic_wrap[%0d]: got %0d expected %0d", i, wrap, w_v[i]); end
            n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL basic_err[%0d]: got %0d expected 0", i, err); end
        end
    endtask

    // sel=2, tc=0: one tick per 8 cycles (when 4 is sampled), cnt stays 0,
    // wrap identical to tick
    task automatic test_tc_zero();
        logic [2:0] d;
        logic       exp_t;
        int         n_ticks;
        sel = 2'd2; tc = 8'd0;
        n_ticks = 0;
        for (int i = 0; i < 16; i++) begin
            d     = 3'((i + 1) % 8);
            exp_t = (d == 3'd4);
            cyc(d);
            if (tick === 1'b1) n_ticks++;
            n_checks++; if (tick !== exp_t) begin n_fail++; $display("FAIL tc0_tick[%0d]: got %0d expected %0d", i, tick, exp_t); end
            n_checks++; if (cnt !== 8'd0)   begin n_fail++; $display("FAIL tc0_cnt[%0d]: got %0d expected 0", i, cnt); end
            n_checks++; if (wrap !== exp_t) begin n_fail++; $display("FAIL tc0_wrap[%0d]: got %0d expected %0d", i, wrap, exp_t); end
        end
        n_checks++; if (n_ticks != 2) begin n_fail++; $display("FAIL tc0_tick_count: got %0d expected 2", n_ticks); end
    endtask

    // Upstream divider held at 0 for 5 cycles, then counting: no error
    task automatic test_upstream_reset();
        enable = 1'b0;
        d_v = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3};
        for (int i = 0; i < 8; i++) begin
            cyc(d_v[i]);
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL upstream_err[%0d]: got %0d expected 0", i, err); end
            n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL upstream_tick[%0d]: got %0d expected 0", i, tick); end
        end
    endtask

    // 3,4 then 6 injected; clear without violation; clear vs violation
    task automatic test_err();
        logic clr_v [8];
        d_v   = '{3'd4, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd5, 3'd6};
        clr_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        e_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            err_clr = clr_v[i];
            cyc(d_v[i]);
            n_checks++; if (err !== e_v[i]) begin n_fail++; $display("FAIL err_seq[%0d]: got %0d expected %0d", i, err, e_v[i]); end
        end
        err_clr = 1'b0;
    endtask

    // Count to 5 with tc=7, lower tc to 2: next rise wraps; then sel=3 and
    // enable=0 suppress ticks and hold cnt
    task automatic test_tc_lower();
        sel = 2'd0; enable = 1'b1; tc = 8'd7;
        d_v = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        c_v = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4};
        for (int i = 0; i < 8; i++) begin
            cyc(d_v[i]);
            n_checks++; if (cnt !== c_v[i]) begin n_fail++; $display("FAIL lower_pre_cnt[%0d]: got %0d expected %0d", i, cnt, c_v[i]); end
        end
        cyc(3'd7);
        n_checks++; if (cnt !== 8'd5) begin n_fail++; $display("FAIL lower_cnt5: got %0d expected 5", cnt); end
        tc = 8'd2;
        cyc(3'd0);
        n_checks++; if (cnt !== 8'd5 || wrap !== 1'b0) begin n_fail++; $display("FAIL lower_idle: got cnt=%0d wrap=%0d expected cnt=5 wrap=0", cnt, wrap); end
        cyc(3'd1);
        n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL lower_wrap_cnt: got %0d expected 0", cnt); end
        n_checks++; if (wrap !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL lower_wrap_pulse: got wrap=%0d tick=%0d expected 1 1", wrap, tick); end
        tc = 8'd7;
        cyc(3'd2);
        cyc(3'd3);
        n_checks++; if (cnt !== 8'd1 || wrap !== 1'b0) begin n_fail++; $display("FAIL lower_recount: got cnt=%0d wrap=%0d expected cnt=1 wrap=0", cnt, wrap); end
        sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            cyc(3'(4 + i));
            n_checks++; if (tick !== 1'b0 || cnt !== 8'd1) begin n_fail++; $display("FAIL sel3_hold[%0d]: got tick=%0d cnt=%0d expected 0 1", i, tick, cnt); end
        end
        sel = 2'd0; enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(3'(6 + i));
            n_checks++; if (tick !== 1'b0 || cnt !== 8'd1) begin n_fail++; $display("FAIL disable_hold[%0d]: got tick=%0d cnt=%0d expected 0 1", i, tick, cnt); end
        end
        enable = 1'b1;
        cyc(3'd0);
    endtask

    // Reach cnt=4 with err set, pull reset low between edges, check the
    // immediate clear, then release on a sample that would violate
    task automatic test_async_reset();
        tc = 8'd7; sel = 2'd0; enable = 1'b1;
        cyc(3'd1);
        cyc(3'd2);
        cyc(3'd3);
        cyc(3'd4);
        cyc(3'd7);
        n_checks++; if (cnt !== 8'd4 || err !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got cnt=%0d err=%0d tick=%0d expected 4 1 1", cnt, err, tick); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (cnt !== 8'd0)  begin n_fail++; $display("FAIL arst_cnt: got %0d expected 0", cnt); end
        n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL arst_tick: got %0d expected 0", tick); end
        n_checks++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL arst_wrap: got %0d expected 0", wrap); end
        n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL arst_err: got %0d expected 0", err); end
        cyc(3'd3);
        n_checks++; if (cnt !== 8'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL arst_hold: got cnt=%0d tick=%0d expected 0 0", cnt, tick); end
        @(negedge clk);
        reset  = 1'b1;
        div_in = 3'd5;
        @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL arst_first_sample_err: got %0d expected 0", err); end
        n_checks++; if (cnt !== 8'd1 || tick !== 1'b1) begin n_fail++; $display("FAIL arst_restart: got cnt=%0d tick=%0d expected 1 1", cnt, tick); end
        cyc(3'd6);
        n_checks++; if (err !== 1'b0 || cnt !== 8'd1) begin n_fail++; $display("FAIL arst_next: got err=%0d cnt=%0d expected 0 1", err, cnt); end
        cyc(3'd7);
        n_checks++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL arst_count: got %0d expected 2", cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tc_zero();
        test_upstream_reset();
        test_err();
        test_tc_lower();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
